alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a registered single-cycle ALU.
// Grants one operation at a time and routes the captured result back.
module alu_arbiter #(
  parameter int unsigned FAIR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  output logic        rsp0_zero,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  output logic        rsp1_zero,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        busy
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CAPT
  } state_t;

  state_t state;
  state_t state_next;

  logic grant;
  logic last;
  logic id;
  logic handshake;
  logic op_known;
  logic [31:0] cap_data;
  logic cap_zero;

  // Tie-break: alternate under FAIR, otherwise requester 0 always wins.
  always_comb begin
    grant = 1'b0;
    case ({req1_valid, req0_valid})
      2'b10:   grant = 1'b1;
      2'b11:   grant = (FAIR != 0) ? ~last : 1'b0;
      default: grant = 1'b0;
    endcase
  end

  assign req0_ready = (state == IDLE) & ~rst
                    & req0_valid & ~grant;
  assign req1_ready = (state == IDLE) & ~rst
                    & req1_valid & grant;
  assign handshake = req0_ready | req1_ready;
  assign busy = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = EXEC;
      EXEC:    state_next = CAPT;
      CAPT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Unknown codes still reach the ALU but report a clean 0 / not-zero.
  always_comb begin
    op_known = 1'b0;
    unique case (1'b1)
      alu_control == OP_AND: op_known = 1'b1;
      alu_control == OP_OR:  op_known = 1'b1;
      alu_control == OP_ADD: op_known = 1'b1;
      alu_control == OP_SUB: op_known = 1'b1;
      alu_control == OP_SLT: op_known = 1'b1;
      alu_control == OP_NOR: op_known = 1'b1;
      default:               op_known = 1'b0;
    endcase
  end

  assign cap_data = op_known ? alu_result : 32'd0;
  assign cap_zero = op_known & alu_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_control <= OP_IDLE;
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      last        <= 1'b1;
      id          <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp0_data   <= 32'd0;
      rsp0_zero   <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_data   <= 32'd0;
      rsp1_zero   <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (handshake) begin
        alu_control <= grant ? req1_op : req0_op;
        alu_a       <= grant ? req1_a : req0_a;
        alu_b       <= grant ? req1_b : req0_b;
        id          <= grant;
        last        <= grant;
      end
      if (state == CAPT) begin
        alu_control <= OP_IDLE;
        if (id) begin
          rsp1_valid <= 1'b1;
          rsp1_data  <= cap_data;
          rsp1_zero  <= cap_zero;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_data  <= cap_data;
          rsp0_zero  <= cap_zero;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a round-robin and a fixed-priority
// instance, each wired to a registered ALU model.
module tb_alu_arbiter;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] AND = 4'b0000;
  localparam logic [3:0] OR  = 4'b0001;
  localparam logic [3:0] SLT = 4'b0111;
  localparam logic [3:0] NOR = 4'b1100;
  localparam logic [3:0] BAD = 4'b1010;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ed;
    logic        ez;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        z;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rdy_fx1 = 0;
  int   rdy_both = 0;

  logic        vld   [2][2];
  logic        rdy   [2][2];
  logic [3:0]  opv   [2][2];
  logic [31:0] av    [2][2];
  logic [31:0] bv    [2][2];
  logic        rsp_v [2][2];
  logic [31:0] rsp_d [2][2];
  logic        rsp_z [2][2];
  logic [3:0]  alu_ctl [2];
  logic [31:0] alu_a   [2];
  logic [31:0] alu_b   [2];
  logic [31:0] alu_res [2];
  logic        alu_z   [2];
  logic        busy    [2];

  vec_t sq [4][$];
  exp_t eq [4][$];
  int   hlog [$];
  int   hcyc [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.FAIR(1)) u_rr (
    .clk(clk), .rst(rst),
    .req0_valid(vld[0][0]), .req0_ready(rdy[0][0]),
    .req0_op(opv[0][0]), .req0_a(av[0][0]), .req0_b(bv[0][0]),
    .req1_valid(vld[0][1]), .req1_ready(rdy[0][1]),
    .req1_op(opv[0][1]), .req1_a(av[0][1]), .req1_b(bv[0][1]),
    .rsp0_valid(rsp_v[0][0]), .rsp0_data(rsp_d[0][0]),
    .rsp0_zero(rsp_z[0][0]),
    .rsp1_valid(rsp_v[0][1]), .rsp1_data(rsp_d[0][1]),
    .rsp1_zero(rsp_z[0][1]),
    .alu_control(alu_ctl[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
    .alu_result(alu_res[0]), .alu_zero(alu_z[0]),
    .busy(busy[0])
  );

  alu_arbiter #(.FAIR(0)) u_fx (
    .clk(clk), .rst(rst),
    .req0_valid(vld[1][0]), .req0_ready(rdy[1][0]),
    .req0_op(opv[1][0]), .req0_a(av[1][0]), .req0_b(bv[1][0]),
    .req1_valid(vld[1][1]), .req1_ready(rdy[1][1]),
    .req1_op(opv[1][1]), .req1_a(av[1][1]), .req1_b(bv[1][1]),
    .rsp0_valid(rsp_v[1][0]), .rsp0_data(rsp_d[1][0]),
    .rsp0_zero(rsp_z[1][0]),
    .rsp1_valid(rsp_v[1][1]), .rsp1_data(rsp_d[1][1]),
    .rsp1_zero(rsp_z[1][1]),
    .alu_control(alu_ctl[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
    .alu_result(alu_res[1]), .alu_zero(alu_z[1]),
    .busy(busy[1])
  );

  // Registered ALU: slt yields 1 when b < a; unknown codes give 0.
  function automatic logic [31:0] alu_f(
    input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      SLT:     return {31'd0, $signed(b) < $signed(a)};
      NOR:     return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_res[0] <= alu_f(alu_ctl[0], alu_a[0], alu_b[0]);
    alu_z[0]   <= (alu_f(alu_ctl[0], alu_a[0], alu_b[0]) == 32'd0);
    alu_res[1] <= alu_f(alu_ctl[1], alu_a[1], alu_b[1]);
    alu_z[1]   <= (alu_f(alu_ctl[1], alu_a[1], alu_b[1]) == 32'd0);
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response pulse appears.
  always @(negedge clk) begin
    if (rdy[1][1] === 1'b1) rdy_fx1++;
    if (rdy[0][0] === 1'b1 && rdy[0][1] === 1'b1) rdy_both++;
    if (rdy[1][0] === 1'b1 && rdy[1][1] === 1'b1) rdy_both++;
    for (int k = 0; k < 4; k++) begin
      if (eq[k].size() != 0 && eq[k][0].due < cyc) begin
        chk($sformatf("missing rsp k%0d", k), 32'd0, 32'd1);
        void'(eq[k].pop_front());
      end
      if (rsp_v[k/2][k%2] !== 1'b0) begin
        if (eq[k].size() == 0) begin
          chk($sformatf("unexpected rsp k%0d", k), 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = eq[k].pop_front();
          chk($sformatf("rsp cycle k%0d", k), cyc, e.due);
          chk($sformatf("rsp data k%0d", k), rsp_d[k/2][k%2], e.d);
          chk($sformatf("rsp zero k%0d", k),
              {31'd0, rsp_z[k/2][k%2]}, {31'd0, e.z});
        end
      end
    end
  end

  task automatic apply();
    for (int k = 0; k < 4; k++) begin
      vld[k/2][k%2] = (sq[k].size() != 0);
      if (sq[k].size() != 0) begin
        opv[k/2][k%2] = sq[k][0].op;
        av[k/2][k%2]  = sq[k][0].a;
        bv[k/2][k%2]  = sq[k][0].b;
      end
    end
  endtask

  task automatic load(input int k, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ed, input logic ez);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.ed = ed; v.ez = ez;
    sq[k].push_back(v);
    apply();
  endtask

  task automatic step();
    bit hs [4];
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      hs[k] = (vld[k/2][k%2] === 1'b1) && (rdy[k/2][k%2] === 1'b1);
      if (hs[k]) begin
        exp_t e;
        e.d = sq[k][0].ed; e.z = sq[k][0].ez; e.due = cyc + 3;
        eq[k].push_back(e);
        hlog.push_back(k);
        hcyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      if (hs[k]) void'(sq[k].pop_front());
    apply();
  endtask

  function automatic bit idle_all();
    for (int k = 0; k < 4; k++)
      if (sq[k].size() != 0 || eq[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while (n < budget && !idle_all()) begin
      step();
      n++;
    end
    if (!idle_all()) begin
      chk({nm, " timeout"}, 32'd1, 32'd0);
      for (int k = 0; k < 4; k++) begin
        sq[k].delete();
        eq[k].delete();
      end
      apply();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst busy%0d", d), {31'd0, busy[d]}, 32'd0);
      chk($sformatf("rst ctl%0d", d), {28'd0, alu_ctl[d]}, 32'hF);
      chk($sformatf("rst a%0d", d), alu_a[d], 32'd0);
      chk($sformatf("rst b%0d", d), alu_b[d], 32'd0);
      for (int r = 0; r < 2; r++) begin
        chk($sformatf("rst rdy%0d%0d", d, r), {31'd0, rdy[d][r]}, 32'd0);
        chk($sformatf("rst rspv%0d%0d", d, r), {31'd0, rsp_v[d][r]}, 32'd0);
        chk($sformatf("rst rspd%0d%0d", d, r), rsp_d[d][r], 32'd0);
        chk($sformatf("rst rspz%0d%0d", d, r), {31'd0, rsp_z[d][r]}, 32'd0);
      end
    end
    for (int k = 0; k < 4; k++) eq[k].delete();
    hlog.delete();
    hcyc.delete();
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    apply();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++) vld[d][r] = 1'b0;
    do_reset();

    load(0, ADD, 32'd5, 32'd7, 32'd12, 1'b0);
    drain("add", 20);
    repeat (3) step();
    chk("hold rsp0 data", rsp_d[0][0], 32'd12);
    chk("rsp1 untouched", rsp_d[0][1], 32'd0);

    load(1, SUB, 32'd9, 32'd9, 32'd0, 1'b1);
    load(1, SUB, -32'sd4, 32'd6, 32'hFFFF_FFF6, 1'b0);
    drain("sub", 20);

    load(0, SLT, 32'd10, 32'd3, 32'd1, 1'b0);
    load(0, NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
    load(0, BAD, 32'd5, 32'd5, 32'd0, 1'b0);
    load(0, AND, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0);
    drain("misc", 40);
    chk("idle ctl", {28'd0, alu_ctl[0]}, 32'hF);
    chk("idle a held", alu_a[0], 32'hF0F0);
    chk("idle b held", alu_b[0], 32'hFF00);

    load(0, ADD, 32'd1, 32'd2, 32'd3, 1'b0);
    load(0, AND, 32'hFF, 32'h0F, 32'h0F, 1'b0);
    load(0, OR, 32'd0, 32'd0, 32'd0, 1'b1);
    load(1, SUB, 32'd100, 32'd1, 32'd99, 1'b0);
    load(1, SLT, -32'sd1, -32'sd5, 32'd1, 1'b0);
    load(1, NOR, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1);
    do_reset();
    drain("fair", 60);
    chk("fair count", hlog.size(), 6);
    for (int i = 0; i < 6 && i < hlog.size(); i++)
      chk($sformatf("fair grant %0d", i), hlog[i], i % 2);
    for (int i = 1; i < 6 && i < hcyc.size(); i++)
      chk($sformatf("fair gap %0d", i), hcyc[i] - hcyc[i-1], 3);

    hlog.delete();
    rdy_fx1 = 0;
    load(2, ADD, -32'sd3, 32'd3, 32'd0, 1'b1);
    load(2, SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
    load(2, OR, 32'h1234, 32'h4321, 32'h5335, 1'b0);
    load(3, ADD, 32'd1, 32'd1, 32'd2, 1'b0);
    load(3, ADD, 32'd2, 32'd2, 32'd4, 1'b0);
    for (int n = 0; n < 30 && sq[2].size() != 0; n++) step();
    sq[3].delete();
    apply();
    drain("fixed", 20);
    chk("fixed count", hlog.size(), 3);
    for (int i = 0; i < hlog.size(); i++)
      chk($sformatf("fixed grant %0d", i), hlog[i], 2);
    chk("fixed rdy1 never", rdy_fx1, 0);

    load(0, ADD, 32'd20, 32'd22, 32'd42, 1'b0);
    for (int n = 0; n < 10 && busy[0] !== 1'b1; n++) step();
    chk("abort in exec", {31'd0, busy[0]}, 32'd1);
    rst = 1'b1;
    eq[0].delete();
    step();
    rst = 1'b0;
    chk("abort busy", {31'd0, busy[0]}, 32'd0);
    load(1, ADD, 32'd7, 32'd8, 32'd15, 1'b0);
    #1;
    chk("resume rdy1", {31'd0, rdy[0][1]}, 32'd1);
    drain("resume", 20);
    repeat (4) step();
    chk("abort rsp0 data", rsp_d[0][0], 32'd0);
    chk("ready overlap", rdy_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
